// File: rtl/led_pattern_sender.sv
// LED pattern source for the NoC data-stream path: one single-beat message per period,
// carrying an 8-bit pattern and a sequence number, with sent/drop counters for monitoring.
module led_pattern_sender #(
  parameter int DATA_WIDTH    = 288,
  parameter int ADDR_WIDTH    = 4,
  parameter int PERIOD_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] dest_addr,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [ADDR_WIDTH-1:0] tx_addr,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic [15:0]           msg_count,
  output logic [15:0]           drop_count,
  output logic                  fsm_state
);

  // Handshake: a message is transferred in any cycle where tx_valid & tx_ready are both 1;
  // once tx_valid is raised, tx_data/tx_addr hold steady and tx_valid stays 1 until that cycle.

  localparam int CW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic [7:0]      pat;
  logic            dir_up;
  logic            first;
  logic [1:0]      last_mode;
  logic [7:0]      next_pat;
  logic            next_dir_up;
  logic [15:0]     seq;

  function automatic logic [DATA_WIDTH-1:0] pack_msg(input logic [15:0] s, input logic [7:0] p);
    pack_msg = '0;
    pack_msg[23:8] = s;
    pack_msg[7:0]  = p;
  endfunction

  assign tick      = enable && (cnt == LAST);
  assign tx_sop    = tx_valid;
  assign tx_eop    = tx_valid;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    next_pat    = pat;
    next_dir_up = dir_up;
    if (first || mode != last_mode) begin
      next_dir_up = 1'b1;
      case (mode)
        2'd0:    next_pat = 8'h00;
        2'd1:    next_pat = 8'h01;
        2'd2:    next_pat = 8'h01;
        default: next_pat = 8'h55;
      endcase
    end else begin
      case (mode)
        2'd0: next_pat = pat + 8'd1;
        2'd1: next_pat = {pat[6:0], pat[7]};
        2'd2: begin
          // Ping-pong reverses at the end bits so each end value appears only once per sweep.
          if (dir_up) begin
            if (pat == 8'h80) begin
              next_pat    = 8'h40;
              next_dir_up = 1'b0;
            end else begin
              next_pat = {pat[6:0], 1'b0};
            end
          end else begin
            if (pat == 8'h01) begin
              next_pat    = 8'h02;
              next_dir_up = 1'b1;
            end else begin
              next_pat = {1'b0, pat[7:1]};
            end
          end
        end
        default: next_pat = ~pat;
      endcase
    end
  end

  // Pattern advances on every tick, whether or not the message gets sent.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pat       <= 8'h00;
      dir_up    <= 1'b1;
      first     <= 1'b1;
      last_mode <= 2'd0;
    end else if (tick) begin
      pat       <= next_pat;
      dir_up    <= next_dir_up;
      first     <= 1'b0;
      last_mode <= mode;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      tx_addr    <= '0;
      seq        <= 16'd0;
      msg_count  <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            tx_data  <= pack_msg(seq, next_pat);
            tx_addr  <= dest_addr;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            seq       <= seq + 16'd1;
            msg_count <= msg_count + 16'd1;
            if (tick) begin
              tx_data <= pack_msg(seq + 16'd1, next_pat);
              tx_addr <= dest_addr;
            end else begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end else if (tick && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_sender.sv
// Bench for led_pattern_sender: directed scenarios plus a randomized run, checked against
// an index-based pattern model and a queue of expected accepted messages.
module tb_led_pattern_sender;
  localparam int DW = 288;
  localparam int AW = 4;
  localparam int PERIOD = 4;

  logic          clk;
  logic          resetn;
  logic          enable;
  logic [1:0]    mode;
  logic [AW-1:0] dest_addr;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;
  logic [AW-1:0] tx_addr;
  logic          tx_sop;
  logic          tx_eop;
  logic [15:0]   msg_count;
  logic [15:0]   drop_count;
  logic          fsm_state;

  int checks = 0;
  int passes = 0;

  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  logic [7:0]  init_tab [4] = '{8'h00, 8'h01, 8'h01, 8'h55};

  led_pattern_sender #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PERIOD_CYCLES(PERIOD)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .mode(mode), .dest_addr(dest_addr),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_addr(tx_addr),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .msg_count(msg_count), .drop_count(drop_count),
    .fsm_state(fsm_state)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the k-th pattern since a (re)start of a mode is computed directly from k.
  int          m_cnt, m_k;
  logic        m_first, m_tick, m_acc, m_valid;
  logic [1:0]  m_last;
  logic [7:0]  m_pat, m_mpat;
  logic [15:0] m_mseq, m_seq, m_msg, m_drop;
  logic [AW-1:0] m_addr;

  function automatic logic [7:0] pat_of(input logic [1:0] md, input int k);
    int p;
    case (md)
      2'd0: pat_of = 8'(k % 256);
      2'd1: pat_of = 8'(1 << (k % 8));
      2'd2: begin
        p = k % 14;
        pat_of = 8'(1 << ((p <= 7) ? p : 14 - p));
      end
      default: pat_of = (k % 2 == 0) ? 8'h55 : 8'hAA;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cnt = 0; m_k = 0; m_first = 1'b1; m_last = 2'd0; m_pat = 8'h00;
      m_valid = 1'b0; m_mpat = 8'h00; m_mseq = 16'd0; m_addr = '0;
      m_seq = 16'd0; m_msg = 16'd0; m_drop = 16'd0;
    end else begin
      m_tick = enable && (m_cnt == PERIOD - 1);
      m_cnt  = enable ? (m_cnt + 1) % PERIOD : 0;
      if (m_tick) begin
        if (m_first || mode != m_last) m_k = 0;
        else m_k = m_k + 1;
        m_pat = pat_of(mode, m_k);
        m_first = 1'b0;
        m_last = mode;
      end
      m_acc = m_valid && tx_ready;
      if (m_acc) begin
        m_seq = m_seq + 16'd1;
        m_msg = m_msg + 16'd1;
      end
      if (m_tick && m_valid && !m_acc) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end else if (m_tick) begin
        m_valid = 1'b1; m_mpat = m_pat; m_mseq = m_seq; m_addr = dest_addr;
      end else if (m_acc) begin
        m_valid = 1'b0;
      end
    end
  end

  logic [63:0] dut_snap;
  assign dut_snap = {tx_valid, tx_sop, tx_eop, tx_valid ? tx_data[23:0] : 24'h0,
                     |tx_data[DW-1:24], tx_valid ? tx_addr : 4'h0, msg_count, drop_count};

  function automatic logic [63:0] exp_snap();
    exp_snap = {m_valid, m_valid, m_valid, m_valid ? {m_mseq, m_mpat} : 24'h0,
                1'b0, m_valid ? m_addr : 4'h0, m_msg, m_drop};
  endfunction

  // Accepted-message monitor, sampled just before each rising edge.
  always @(negedge clk) begin
    #4;
    if (resetn && tx_valid && tx_ready) got_q.push_back(tx_data[23:0]);
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; enable = 1'b0; mode = 2'd0; tx_ready = 1'b0; dest_addr = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0; enable = 1'b1; mode = 2'd0; tx_ready = 1'b0; dest_addr = '0;
    #1;
    checks++;
    if ({tx_valid, tx_sop, tx_eop, tx_data, tx_addr, msg_count, drop_count, fsm_state} !== '0)
      $display("FAIL reset_outputs got valid=%b data=%h msg=%h drop=%h state=%b exp all zero",
               tx_valid, tx_data[23:0], msg_count, drop_count, fsm_state);
    else passes++;
  endtask

  task automatic test_count();
    logic [23:0] e, g;
    do_reset();
    enable = 1'b1; mode = 2'd0; tx_ready = 1'b1; dest_addr = AW'($urandom_range(0, 15));
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      checks++;
      if (dut_snap !== exp_snap()) $display("FAIL count_cyc%0d got=%h exp=%h", i, dut_snap, exp_snap());
      else passes++;
    end
    checks++;
    if (msg_count !== 16'd3 || drop_count !== 16'd0)
      $display("FAIL count_totals got msg=%0d drop=%0d exp msg=3 drop=0", msg_count, drop_count);
    else passes++;
    for (int i = 0; i < 3; i++) exp_q.push_back({16'(i), 8'(i)});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 24'hxxxxxx;
      checks++;
      if (g !== e) $display("FAIL count_msg got=%h exp=%h", g, e);
      else passes++;
    end
  endtask

  task automatic test_pingpong();
    logic [7:0] tab [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                             8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [23:0] e, g;
    do_reset();
    enable = 1'b1; mode = 2'd2; tx_ready = 1'b1;
    for (int i = 1; i <= 66; i++) begin
      @(negedge clk);
      checks++;
      if (dut_snap !== exp_snap()) $display("FAIL pingpong_cyc%0d got=%h exp=%h", i, dut_snap, exp_snap());
      else passes++;
    end
    for (int i = 0; i < 16; i++) exp_q.push_back({16'(i), tab[i]});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 24'hxxxxxx;
      checks++;
      if (g !== e) $display("FAIL pingpong_msg got=%h exp=%h", g, e);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1; mode = 2'd0; tx_ready = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checks++;
      if (dut_snap !== exp_snap()) $display("FAIL bp_cyc%0d got=%h exp=%h", i, dut_snap, exp_snap());
      else passes++;
      if (i >= 4) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data[23:0] !== 24'h000000)
          $display("FAIL bp_hold_cyc%0d got valid=%b data=%h exp valid=1 data=000000", i, tx_valid, tx_data[23:0]);
        else passes++;
      end
    end
    checks++;
    if (drop_count !== 16'd9) $display("FAIL bp_drops got=%0d exp=9", drop_count);
    else passes++;
    tx_ready = 1'b1;
    for (int i = 41; i <= 44; i++) begin
      @(negedge clk);
      checks++;
      if (dut_snap !== exp_snap()) $display("FAIL bp_cyc%0d got=%h exp=%h", i, dut_snap, exp_snap());
      else passes++;
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data[23:0] !== {16'd1, 8'h0A})
      $display("FAIL bp_next got valid=%b data=%h exp valid=1 data=00010a", tx_valid, tx_data[23:0]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    enable = 1'b1; mode = 2'd0; tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checks++;
      if (dut_snap !== exp_snap()) $display("FAIL b2b_cyc%0d got=%h exp=%h", i, dut_snap, exp_snap());
      else passes++;
      if (i >= 4 && i <= 8) begin
        checks++;
        if (tx_valid !== 1'b1) $display("FAIL b2b_gap_cyc%0d got valid=%b exp 1", i, tx_valid);
        else passes++;
      end
      if (i == 8) begin
        checks++;
        if (tx_data[23:0] !== {16'd1, 8'h01} || drop_count !== 16'd0 || msg_count !== 16'd1)
          $display("FAIL b2b_reload got data=%h drop=%0d msg=%0d exp data=000101 drop=0 msg=1",
                   tx_data[23:0], drop_count, msg_count);
        else passes++;
      end
      if (i == 7) tx_ready = 1'b1;
    end
  endtask

  task automatic test_mode_switch();
    logic [7:0] tab [7] = '{8'h01, 8'h02, 8'h04, 8'h55, 8'hAA, 8'h55, 8'h01};
    logic [23:0] e, g;
    do_reset();
    enable = 1'b1; mode = 2'd1; tx_ready = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      checks++;
      if (dut_snap !== exp_snap()) $display("FAIL mode_cyc%0d got=%h exp=%h", i, dut_snap, exp_snap());
      else passes++;
      if (i == 12) mode = 2'd3;
      if (i == 24) mode = 2'd1;
    end
    for (int i = 0; i < 7; i++) exp_q.push_back({16'(i), tab[i]});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 24'hxxxxxx;
      checks++;
      if (g !== e) $display("FAIL mode_msg got=%h exp=%h", g, e);
      else passes++;
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] md;
    md = 2'($urandom_range(0, 3));
    do_reset();
    enable = 1'b1; mode = md; tx_ready = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      checks++;
      if (dut_snap !== exp_snap()) $display("FAIL rst_cyc%0d got=%h exp=%h", i, dut_snap, exp_snap());
      else passes++;
      if (i == 9) tx_ready = 1'b0;
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({tx_valid, tx_data, tx_addr, msg_count, drop_count} !== '0)
      $display("FAIL rst_async got valid=%b data=%h msg=%0d drop=%0d exp all zero",
               tx_valid, tx_data[23:0], msg_count, drop_count);
    else passes++;
    @(negedge clk);
    resetn = 1'b1; tx_ready = 1'b1;
    got_q.delete();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (dut_snap !== exp_snap()) $display("FAIL rst_after_cyc%0d got=%h exp=%h", i, dut_snap, exp_snap());
      else passes++;
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {16'd0, init_tab[md]})
      $display("FAIL rst_first_msg got n=%0d data=%h exp n=1 data=%h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 24'h0, {16'd0, init_tab[md]});
    else passes++;
  endtask

  task automatic test_enable_gap();
    do_reset();
    enable = 1'b1; mode = 2'd0; tx_ready = 1'b1;
    repeat (6) @(negedge clk);
    enable = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0) $display("FAIL en_off_cyc%0d got valid=%b exp 0", i, tx_valid);
      else passes++;
    end
    enable = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== (j == 4)) $display("FAIL en_on_cyc%0d got valid=%b exp %0d", j, tx_valid, (j == 4));
      else passes++;
    end
  endtask

  task automatic test_random();
    do_reset();
    enable = 1'b1; mode = 2'($urandom_range(0, 3)); tx_ready = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      checks++;
      if (dut_snap !== exp_snap()) $display("FAIL rand_cyc%0d got=%h exp=%h", i, dut_snap, exp_snap());
      else passes++;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      tx_ready  = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 19) != 0);
      dest_addr = AW'($urandom_range(0, 15));
    end
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; mode = 2'd0; tx_ready = 1'b0; dest_addr = '0;
    test_reset();
    test_count();
    test_pingpong();
    test_backpressure();
    test_back_to_back();
    test_mode_switch();
    test_reset_midflight();
    test_enable_gap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
